// File: rtl/rl_ram_1r1w_clr_ctrl.sv
// Front-end sequencer for a single 1R1W RAM: fills the whole array on reset or request,
// otherwise passes user traffic through and forwards same-address write bytes into reads.
module rl_ram_1r1w_clr_ctrl #(
    parameter int                ABITS         = 8,
    parameter int                DBITS         = 8,
    parameter bit                INIT_ON_RESET = 1'b1,
    parameter logic [DBITS-1:0]  INIT_VALUE    = '0,
    localparam int               BE            = (DBITS + 7) / 8
) (
    input  logic              rstn,
    input  logic              clk,
    input  logic              clr_req,
    input  logic [DBITS-1:0]  fill,
    output logic              busy,
    input  logic [ABITS-1:0]  waddr,
    input  logic [DBITS-1:0]  din,
    input  logic              we,
    input  logic [BE-1:0]     be,
    output logic              wready,
    input  logic [ABITS-1:0]  raddr,
    input  logic              re,
    output logic              rready,
    output logic [DBITS-1:0]  dout,
    output logic              dout_valid,
    output logic [ABITS-1:0]  ram_waddr,
    output logic [DBITS-1:0]  ram_din,
    output logic              ram_we,
    output logic [BE-1:0]     ram_be,
    output logic [ABITS-1:0]  ram_raddr,
    output logic              ram_re,
    input  logic [DBITS-1:0]  ram_dout
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ABITS-1:0] LAST_ADDR = {ABITS{1'b1}};
    localparam state_t RESET_STATE = INIT_ON_RESET ? CLEAR : IDLE;

    state_t             state_reg, state_next;
    logic [ABITS-1:0]   cnt_reg, cnt_next;
    logic [DBITS-1:0]   fill_reg, fill_next;
    logic               dout_valid_reg;
    logic               fwd_reg;
    logic [DBITS-1:0]   din_reg;
    logic [DBITS-1:0]   biten_reg;
    logic [DBITS-1:0]   be_bits;
    logic               idle;
    logic               rd_acc;
    logic               collide;

    // Per-bit mask from the byte enables: bit i follows lane i/8.
    generate
        for (genvar gi = 0; gi < DBITS; gi++) begin : g_biten
            assign be_bits[gi] = be[gi / 8];
        end
    endgenerate

    assign idle    = (state_reg == IDLE);
    assign busy    = (state_reg == CLEAR);
    assign wready  = idle;
    assign rready  = idle;
    assign rd_acc  = re & idle;
    assign collide = rd_acc & we & (raddr == waddr);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        fill_next  = fill_reg;
        ram_we     = 1'b0;
        ram_waddr  = waddr;
        ram_din    = din;
        ram_be     = be;
        ram_re     = 1'b0;
        ram_raddr  = raddr;
        case (state_reg)
            IDLE: begin
                ram_we = we;
                ram_re = re;
                if (clr_req) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                    fill_next  = fill;
                end
            end
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = cnt_reg;
                ram_din   = fill_reg;
                ram_be    = '1;
                // Counter parks on the last address instead of wrapping.
                if (cnt_reg == LAST_ADDR) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= RESET_STATE;
            cnt_reg        <= '0;
            fill_reg       <= INIT_VALUE;
            dout_valid_reg <= 1'b0;
            fwd_reg        <= 1'b0;
            din_reg        <= '0;
            biten_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            fill_reg       <= fill_next;
            dout_valid_reg <= rd_acc;
            fwd_reg        <= collide;
            if (collide) begin
                din_reg   <= din;
                biten_reg <= be_bits;
            end
        end
    end

    // The RAM returns pre-write data on a collision, so overlay the written bytes.
    assign dout       = fwd_reg ? ((ram_dout & ~biten_reg) | (din_reg & biten_reg)) : ram_dout;
    assign dout_valid = dout_valid_reg;

endmodule

// File: tb/tb_rl_ram_1r1w_clr_ctrl.sv
// Directed bench: two controllers (fill-on-reset and idle-on-reset), each with a behavioural RAM.
module tb_rl_ram_1r1w_clr_ctrl;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses0  = 0;

    // DUT 1: INIT_ON_RESET=1, INIT_VALUE=A5A5
    logic        clr_req, we, re, busy, wready, rready, dout_valid, ram_we, ram_re;
    logic [15:0] fill, din, dout, ram_din, ram_dout;
    logic [3:0]  waddr, raddr, ram_waddr, ram_raddr;
    logic [1:0]  be, ram_be;
    logic [15:0] mem1 [16];

    // DUT 0: INIT_ON_RESET=0
    logic        clr_req0, we0, re0, busy0, wready0, rready0, dout_valid0, ram_we0, ram_re0;
    logic [15:0] fill0, din0, dout0, ram_din0, ram_dout0;
    logic [3:0]  waddr0, raddr0, ram_waddr0, ram_raddr0;
    logic [1:0]  be0, ram_be0;
    logic [15:0] mem0 [16];

    logic [15:0] shadow1 [16];
    logic [15:0] shadow0 [16];
    logic [15:0] q1 [$];
    logic [15:0] q0 [$];

    rl_ram_1r1w_clr_ctrl #(.ABITS(4), .DBITS(16), .INIT_ON_RESET(1'b1), .INIT_VALUE(16'hA5A5)) dut1 (
        .rstn(rstn), .clk(clk), .clr_req(clr_req), .fill(fill), .busy(busy),
        .waddr(waddr), .din(din), .we(we), .be(be), .wready(wready),
        .raddr(raddr), .re(re), .rready(rready), .dout(dout), .dout_valid(dout_valid),
        .ram_waddr(ram_waddr), .ram_din(ram_din), .ram_we(ram_we), .ram_be(ram_be),
        .ram_raddr(ram_raddr), .ram_re(ram_re), .ram_dout(ram_dout)
    );

    rl_ram_1r1w_clr_ctrl #(.ABITS(4), .DBITS(16), .INIT_ON_RESET(1'b0), .INIT_VALUE(16'h0000)) dut0 (
        .rstn(rstn), .clk(clk), .clr_req(clr_req0), .fill(fill0), .busy(busy0),
        .waddr(waddr0), .din(din0), .we(we0), .be(be0), .wready(wready0),
        .raddr(raddr0), .re(re0), .rready(rready0), .dout(dout0), .dout_valid(dout_valid0),
        .ram_waddr(ram_waddr0), .ram_din(ram_din0), .ram_we(ram_we0), .ram_be(ram_be0),
        .ram_raddr(ram_raddr0), .ram_re(ram_re0), .ram_dout(ram_dout0)
    );

    // Behavioural 1R1W RAMs: 1-cycle read latency, read returns pre-write contents.
    always @(posedge clk) begin
        if (ram_re) ram_dout <= mem1[ram_raddr];
        if (ram_we)
            for (int b = 0; b < 2; b++)
                if (ram_be[b]) mem1[ram_waddr][b*8 +: 8] <= ram_din[b*8 +: 8];
    end

    always @(posedge clk) begin
        if (ram_re0) ram_dout0 <= mem0[ram_raddr0];
        if (ram_we0)
            for (int b = 0; b < 2; b++)
                if (ram_be0[b]) mem0[ram_waddr0][b*8 +: 8] <= ram_din0[b*8 +: 8];
    end

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] b);
        logic [15:0] m;
        m = {{8{b[1]}}, {8{b[0]}}};
        return (old & ~m) | (d & m);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and retire any read issued before that edge.
    task automatic tick();
        logic [15:0] e;
        @(posedge clk);
        #1;
        check("d1_dout_valid", {31'b0, dout_valid}, {31'b0, q1.size() != 0});
        if (q1.size() != 0) begin
            e = q1.pop_front();
            check("d1_dout", {16'b0, dout}, {16'b0, e});
        end
        check("d0_dout_valid", {31'b0, dout_valid0}, {31'b0, q0.size() != 0});
        if (q0.size() != 0) begin
            e = q0.pop_front();
            check("d0_dout", {16'b0, dout0}, {16'b0, e});
        end
        if (dout_valid0) pulses0++;
    endtask

    task automatic op1(input logic w, input logic [3:0] wa, input logic [15:0] d, input logic [1:0] b,
                       input logic r, input logic [3:0] ra);
        we = w; waddr = wa; din = d; be = b; re = r; raddr = ra;
        if (w) shadow1[wa] = merge(shadow1[wa], d, b);
        if (r) q1.push_back(shadow1[ra]);
    endtask

    task automatic op0(input logic w, input logic [3:0] wa, input logic [15:0] d, input logic r, input logic [3:0] ra);
        we0 = w; waddr0 = wa; din0 = d; be0 = 2'b11; re0 = r; raddr0 = ra;
        if (w) shadow0[wa] = d;
        if (r) q0.push_back(shadow0[ra]);
    endtask

    // Walk a full fill on dut1; disturb=1 pokes clr_req and user traffic mid-fill.
    task automatic clear_run(input logic [15:0] f, input bit disturb);
        for (int i = 0; i < 16; i++) begin
            if (disturb && i == 2) begin
                we = 1'b1; waddr = 4'd2; din = 16'hFFFF; be = 2'b01; re = 1'b1; raddr = 4'd7;
            end
            if (disturb && i == 8) begin clr_req = 1'b1; fill = 16'h1111; end
            if (disturb && i == 9) clr_req = 1'b0;
            if (disturb && i == 15) begin we = 1'b0; re = 1'b0; end
            check("clr_busy", {31'b0, busy}, 32'd1);
            check("clr_wready", {31'b0, wready}, 32'd0);
            check("clr_ram_we", {31'b0, ram_we}, 32'd1);
            check("clr_ram_re", {31'b0, ram_re}, 32'd0);
            check("clr_ram_be", {30'b0, ram_be}, 32'd3);
            check("clr_ram_waddr", {28'b0, ram_waddr}, i);
            check("clr_ram_din", {16'b0, ram_din}, {16'b0, f});
            tick();
        end
        check("clr_done_busy", {31'b0, busy}, 32'd0);
        check("clr_done_wready", {31'b0, wready}, 32'd1);
        for (int a = 0; a < 16; a++) shadow1[a] = f;
    endtask

    initial begin
        clr_req = 0; fill = 0; we = 0; re = 0; din = 0; be = 0; waddr = 0; raddr = 0;
        clr_req0 = 0; fill0 = 0; we0 = 0; re0 = 0; din0 = 0; be0 = 0; waddr0 = 0; raddr0 = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy1", {31'b0, busy}, 32'd1);
        check("rst_wready1", {31'b0, wready}, 32'd0);
        check("rst_valid1", {31'b0, dout_valid}, 32'd0);
        check("rst_busy0", {31'b0, busy0}, 32'd0);
        rstn = 1'b1;
        check("rel_busy0", {31'b0, busy0}, 32'd0);
        check("rel_wready0", {31'b0, wready0}, 32'd1);
        check("rel_rready0", {31'b0, rready0}, 32'd1);

        // Post-reset fill, then read back every address
        clear_run(16'hA5A5, 1'b0);
        for (int a = 0; a < 16; a++) begin
            op1(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, a[3:0]);
            tick();
        end
        op1(0, 0, 0, 0, 0, 0); tick();

        // Byte-enabled partial write
        op1(1'b1, 4'd3, 16'h1234, 2'b11, 1'b0, 4'd0); tick();
        op1(1'b1, 4'd3, 16'hFFCD, 2'b01, 1'b0, 4'd0); tick();
        op1(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd3);
        check("partial_model", {16'b0, q1[0]}, 32'h12CD);
        tick();
        op1(0, 0, 0, 0, 0, 0); tick();

        // Same-cycle same-address collision with forwarding
        op1(1'b1, 4'd5, 16'h0000, 2'b11, 1'b0, 4'd0); tick();
        op1(1'b1, 4'd5, 16'hBEEF, 2'b10, 1'b1, 4'd5);
        check("collide_model", {16'b0, q1[0]}, 32'hBE00);
        tick();
        op1(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd5); tick();
        op1(0, 0, 0, 0, 0, 0); tick();

        // Requested fill, re-requested mid-fill with user traffic held
        clr_req = 1'b1; fill = 16'h0F0F; tick();
        clr_req = 1'b0; fill = 16'h0000;
        clear_run(16'h0F0F, 1'b1);
        tick();
        check("no_restart_busy", {31'b0, busy}, 32'd0);
        for (int a = 0; a < 16; a += 5) begin
            op1(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, a[3:0]);
            tick();
        end
        op1(0, 0, 0, 0, 0, 0); tick();

        // Reset during a fill aborts it; INIT_VALUE fill restarts from 0
        clr_req = 1'b1; fill = 16'h3C3C; tick();
        clr_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("pre_rst_waddr", {28'b0, ram_waddr}, i);
            tick();
        end
        rstn = 1'b0;
        #1;
        check("mid_rst_busy", {31'b0, busy}, 32'd1);
        check("mid_rst_waddr", {28'b0, ram_waddr}, 32'd0);
        check("mid_rst_din", {16'b0, ram_din}, 32'hA5A5);
        check("mid_rst_valid", {31'b0, dout_valid}, 32'd0);
        tick();
        rstn = 1'b1;
        clear_run(16'hA5A5, 1'b0);
        op1(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd9); tick();
        op1(0, 0, 0, 0, 0, 0); tick();

        // Idle-on-reset instance: fill by writes, then 16 back-to-back reads
        for (int a = 0; a < 16; a++) begin
            op0(1'b1, a[3:0], 16'h1000 + 16'(a) * 16'h0111, 1'b0, 4'd0);
            tick();
        end
        pulses0 = 0;
        for (int a = 0; a < 16; a++) begin
            op0(1'b0, 4'd0, 16'h0, 1'b1, a[3:0]);
            tick();
        end
        op0(0, 0, 0, 0, 0); tick();
        check("d0_pulses", pulses0, 32'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
